// File: rtl/video_timing_measure.sv
// Per-frame video statistics: valid pixels, lines, min/max line length,
// overflow, frame-to-frame lock and no-signal timeout.
module video_timing_measure #(
  parameter int PIX_W         = 32,
  parameter int CNT_W         = 16,
  parameter int HS_POL        = 1,
  parameter int VS_POL        = 1,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT       = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic             valid_i,
  output logic             frame_done_o,
  output logic [PIX_W-1:0] pix_count_o,
  output logic [CNT_W-1:0] line_count_o,
  output logic [CNT_W-1:0] line_min_o,
  output logic [CNT_W-1:0] line_max_o,
  output logic             ovf_o,
  output logic             locked_o,
  output logic             no_signal_o
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int MW    = $clog2(STABLE_FRAMES);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [MW-1:0]    MATCH_LAST = MW'(STABLE_FRAMES - 1);
  localparam logic HS_INV = (HS_POL == 0);
  localparam logic VS_INV = (VS_POL == 0);

  logic s1_hs, s1_vs, s1_valid, s2_hs, s2_vs;
  logic hs_rise, hs_fall, vs_rise, vs_fall, pix_inc;

  logic [CNT_W-1:0] line_len, line_len_nx;
  logic [PIX_W-1:0] pix, pix_nx;
  logic [CNT_W-1:0] lines, lines_nx;
  logic [CNT_W-1:0] lmin, min_nx, lmax, max_nx, frame_min;
  logic             ovf, ovf_nx, same;
  logic [MW-1:0]    match, match_nx;
  logic [TMR_W-1:0] timer;

  assign hs_rise = s1_hs & ~s2_hs;
  assign hs_fall = ~s1_hs & s2_hs;
  assign vs_rise = s1_vs & ~s2_vs;
  assign vs_fall = ~s1_vs & s2_vs;
  assign pix_inc = s1_hs & s1_valid & s1_vs;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    line_len_nx = hs_rise ? '0 : line_len;
    pix_nx      = vs_rise ? '0 : pix;
    lines_nx    = vs_rise ? '0 : lines;
    min_nx      = vs_rise ? '1 : lmin;
    max_nx      = vs_rise ? '0 : lmax;
    ovf_nx      = vs_rise ? 1'b0 : ovf;
    if (pix_inc) begin
      if (&line_len_nx) ovf_nx = 1'b1;
      else              line_len_nx = line_len_nx + 1'b1;
      if (&pix_nx) ovf_nx = 1'b1;
      else         pix_nx = pix_nx + 1'b1;
    end
    // A line closing on the same edge as the frame is folded in before the frame latches.
    if (hs_fall && s2_vs) begin
      if (&lines_nx) ovf_nx = 1'b1;
      else           lines_nx = lines_nx + 1'b1;
      if (line_len < min_nx) min_nx = line_len;
      if (line_len > max_nx) max_nx = line_len;
    end
    frame_min = (lines_nx == '0) ? '0 : min_nx;
    same = ({pix_nx, lines_nx, frame_min, max_nx} ==
            {pix_count_o, line_count_o, line_min_o, line_max_o}) && !ovf_nx;
    match_nx = '0;
    if (same) match_nx = (match == MATCH_LAST) ? MATCH_LAST : match + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s1_valid     <= 1'b0;
      s2_hs        <= 1'b0;
      s2_vs        <= 1'b0;
      line_len     <= '0;
      pix          <= '0;
      lines        <= '0;
      lmin         <= '1;
      lmax         <= '0;
      ovf          <= 1'b0;
      match        <= '0;
      timer        <= '0;
      frame_done_o <= 1'b0;
      pix_count_o  <= '0;
      line_count_o <= '0;
      line_min_o   <= '0;
      line_max_o   <= '0;
      ovf_o        <= 1'b0;
      locked_o     <= 1'b0;
      no_signal_o  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      frame_done_o <= 1'b0;
      if (clk_en) begin
        s1_hs    <= hs_i ^ HS_INV;
        s1_vs    <= vs_i ^ VS_INV;
        s1_valid <= valid_i;
        s2_hs    <= s1_hs;
        s2_vs    <= s1_vs;
        line_len <= line_len_nx;
        pix      <= pix_nx;
        lines    <= lines_nx;
        lmin     <= min_nx;
        lmax     <= max_nx;
        ovf      <= ovf_nx;
        if (vs_fall) begin
          pix_count_o  <= pix_nx;
          line_count_o <= lines_nx;
          line_min_o   <= frame_min;
          line_max_o   <= max_nx;
          ovf_o        <= ovf_nx;
          frame_done_o <= 1'b1;
          match        <= match_nx;
          locked_o     <= (match_nx == MATCH_LAST);
        end
        // Timeout takes priority over any lock update on the same edge.
        if (vs_rise) begin
          timer       <= '0;
          no_signal_o <= 1'b0;
        end else if (timer == TMR_LAST) begin
          no_signal_o <= 1'b1;
          locked_o    <= 1'b0;
          match       <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_measure.sv
// Scoreboard bench: two instances (4-bit counters / positive syncs, and
// 16-bit counters / inverted syncs) driven by the same directed frames.
module tb_video_timing_measure;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic hs = 1'b0, vs = 1'b0, valid = 1'b0;
  logic hs_inv, vs_inv;

  logic        fd_p, ovf_p, lk_p, ns_p;
  logic [31:0] pix_p;
  logic [3:0]  lc_p, mn_p, mx_p;
  logic        fd_n, ovf_n, lk_n, ns_n;
  logic [31:0] pix_n;
  logic [15:0] lc_n, mn_n, mx_n;

  assign hs_inv = ~hs;
  assign vs_inv = ~vs;

  always #5 clk = ~clk;

  video_timing_measure #(.PIX_W(32), .CNT_W(4), .HS_POL(1), .VS_POL(1),
                         .STABLE_FRAMES(4), .TIMEOUT(64)) dut_p (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .hs_i(hs), .vs_i(vs), .valid_i(valid),
    .frame_done_o(fd_p), .pix_count_o(pix_p), .line_count_o(lc_p), .line_min_o(mn_p),
    .line_max_o(mx_p), .ovf_o(ovf_p), .locked_o(lk_p), .no_signal_o(ns_p));

  video_timing_measure #(.PIX_W(32), .CNT_W(16), .HS_POL(0), .VS_POL(0),
                         .STABLE_FRAMES(4), .TIMEOUT(64)) dut_n (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .hs_i(hs_inv), .vs_i(vs_inv), .valid_i(valid),
    .frame_done_o(fd_n), .pix_count_o(pix_n), .line_count_o(lc_n), .line_min_o(mn_n),
    .line_max_o(mx_n), .ovf_o(ovf_n), .locked_o(lk_n), .no_signal_o(ns_n));

  typedef struct packed {
    logic [31:0] pix;
    logic [15:0] lines;
    logic [15:0] mn;
    logic [15:0] mx;
    logic        ovf;
    logic        locked;
  } exp_t;

  exp_t q_p[$];
  exp_t q_n[$];
  int n_pass = 0, n_total = 0;
  int en_edges = 0, last_rise = 0;
  bit toggle_en = 1'b0;
  int prev_pix[2], prev_lines[2], prev_mn[2], prev_mx[2], match[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clk_en cycle of stimulus; in toggle mode a disabled cycle follows.
  task automatic cyc(input logic h, input logic v, input logic d);
    hs = h; vs = v; valid = d;
    clk_en = 1'b1;
    @(posedge clk); #1;
    en_edges++;
    if (toggle_en) begin
      clk_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      prev_pix[d] = 0; prev_lines[d] = 0; prev_mn[d] = 0; prev_mx[d] = 0; match[d] = 0;
    end
  endtask

  task automatic expect_frame(input int n, input int l0, input int l1, input int l2);
    int l[3];
    l = '{l0, l1, l2};
    for (int d = 0; d < 2; d++) begin
      int sat, pix, mn, mx, c;
      bit ovf, same;
      exp_t e;
      sat = (d == 0) ? 15 : 65535;
      pix = 0; mn = sat; mx = 0; ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
        pix += l[i];
        c = (l[i] > sat) ? sat : l[i];
        if (l[i] > sat) ovf = 1'b1;
        if (c < mn) mn = c;
        if (c > mx) mx = c;
      end
      if (n == 0) mn = 0;
      same = (pix == prev_pix[d]) && (n == prev_lines[d]) && (mn == prev_mn[d]) &&
             (mx == prev_mx[d]) && !ovf;
      match[d] = same ? ((match[d] == 3) ? 3 : match[d] + 1) : 0;
      prev_pix[d] = pix; prev_lines[d] = n; prev_mn[d] = mn; prev_mx[d] = mx;
      e.pix = 32'(pix); e.lines = 16'(n); e.mn = 16'(mn); e.mx = 16'(mx);
      e.ovf = ovf; e.locked = (match[d] == 3);
      if (d == 0) q_p.push_back(e);
      else        q_n.push_back(e);
    end
  endtask

  // Line of len valid pixels with one gap in the middle; valid is high for one
  // hs-inactive cycle to show it is ignored there.
  task automatic send_line(input int len, input bit drop_vs);
    int h;
    h = len / 2;
    for (int i = 0; i <= len; i++) cyc(1'b1, 1'b1, i != h);
    if (drop_vs) cyc(1'b0, 1'b0, 1'b0);
    else begin
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic send_frame(input int n, input int l0, input int l1, input int l2, input bit joint);
    int l[3];
    l = '{l0, l1, l2};
    expect_frame(n, l0, l1, l2);
    cyc(1'b0, 1'b1, 1'b0);
    last_rise = en_edges + 1;
    for (int i = 0; i < n; i++) send_line(l[i], joint && (i == n - 1));
    if (!joint) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_p_done"}, 64'(fd_p), 0);
    check({tag, "_p_pix"}, 64'(pix_p), 0);
    check({tag, "_p_lines"}, 64'(lc_p), 0);
    check({tag, "_p_min"}, 64'(mn_p), 0);
    check({tag, "_p_max"}, 64'(mx_p), 0);
    check({tag, "_p_ovf"}, 64'(ovf_p), 0);
    check({tag, "_p_locked"}, 64'(lk_p), 0);
    check({tag, "_p_nosig"}, 64'(ns_p), 0);
    check({tag, "_n_done"}, 64'(fd_n), 0);
    check({tag, "_n_pix"}, 64'(pix_n), 0);
    check({tag, "_n_lines"}, 64'(lc_n), 0);
    check({tag, "_n_min"}, 64'(mn_n), 0);
    check({tag, "_n_max"}, 64'(mx_n), 0);
    check({tag, "_n_ovf"}, 64'(ovf_n), 0);
    check({tag, "_n_locked"}, 64'(lk_n), 0);
    check({tag, "_n_nosig"}, 64'(ns_n), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fd_p) begin
      if (q_p.size() == 0) check("p_unexpected_frame_done", 64'(fd_p), 0);
      else begin
        e = q_p.pop_front();
        check("p_pix", 64'(pix_p), 64'(e.pix));
        check("p_lines", 64'(lc_p), 64'(e.lines));
        check("p_min", 64'(mn_p), 64'(e.mn));
        check("p_max", 64'(mx_p), 64'(e.mx));
        check("p_ovf", 64'(ovf_p), 64'(e.ovf));
        check("p_locked", 64'(lk_p), 64'(e.locked));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (fd_n) begin
      if (q_n.size() == 0) check("n_unexpected_frame_done", 64'(fd_n), 0);
      else begin
        e = q_n.pop_front();
        check("n_pix", 64'(pix_n), 64'(e.pix));
        check("n_lines", 64'(lc_n), 64'(e.lines));
        check("n_min", 64'(mn_n), 64'(e.mn));
        check("n_max", 64'(mx_n), 64'(e.mx));
        check("n_ovf", 64'(ovf_n), 64'(e.ovf));
        check("n_locked", 64'(lk_n), 64'(e.locked));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    reset_model();

    // Four identical frames reach lock; one extra pixel drops it.
    repeat (4) send_frame(3, 8, 10, 6, 1'b0);
    send_frame(3, 8, 11, 6, 1'b0);
    // Last line's hs fall coincides with vs fall.
    send_frame(3, 8, 10, 6, 1'b1);
    // 20-pixel line saturates the 4-bit instance only; next frame is clean.
    send_frame(1, 20, 0, 0, 1'b0);
    send_frame(3, 8, 10, 6, 1'b0);

    toggle_en = 1'b1;
    send_frame(3, 8, 10, 6, 1'b0);
    toggle_en = 1'b0;

    // Reset mid-frame with clk_en low; the remainder closes as a partial frame.
    cyc(1'b0, 1'b1, 1'b0);
    send_line(8, 1'b0);
    rst_n = 1'b0; clk_en = 1'b0;
    @(posedge clk); #1;
    chk_zero("midreset");
    rst_n = 1'b1;
    reset_model();
    expect_frame(1, 6, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    send_line(6, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    send_frame(3, 8, 10, 6, 1'b0);

    // Relock, then stop vs and wait out the 64-cycle timeout.
    repeat (3) send_frame(3, 8, 10, 6, 1'b0);
    while (en_edges < last_rise + 63) cyc(1'b0, 1'b0, 1'b0);
    check("p_nosig_before_timeout", 64'(ns_p), 0);
    check("n_nosig_before_timeout", 64'(ns_n), 0);
    check("p_locked_before_timeout", 64'(lk_p), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("p_nosig_at_timeout", 64'(ns_p), 1);
    check("n_nosig_at_timeout", 64'(ns_n), 1);
    check("p_locked_at_timeout", 64'(lk_p), 0);
    check("n_locked_at_timeout", 64'(lk_n), 0);
    check("p_pix_held_at_timeout", 64'(pix_p), 24);
    for (int d = 0; d < 2; d++) match[d] = 0;
    cyc(1'b0, 1'b1, 1'b0);
    check("p_nosig_before_rise", 64'(ns_p), 1);
    cyc(1'b0, 1'b1, 1'b0);
    check("p_nosig_after_rise", 64'(ns_p), 0);
    check("n_nosig_after_rise", 64'(ns_n), 0);
    send_frame(3, 8, 10, 6, 1'b0);

    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    check("p_all_frames_seen", 64'(q_p.size()), 0);
    check("n_all_frames_seen", 64'(q_n.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
